mem_reinit_sequencer: RTL and testbench
=======================================

Name: mem_reinit_sequencer

Overview:
- Controller for the 512x64 simple-dual-port block RAM (one read port, one write port, which writes every clock).
- Owns the RAM's raddr/waddr/din during a reinit run: fills every word with a pattern, then reads every word back and checks it against that pattern.
- When idle, passes a user port straight through to the RAM.
- Sits between user logic and the memory instance; reports pass/fail, error count and first failing address.

Parameters:
WID_MEM, 64, data width of RAM word
DEPTH_MEM, 512, number of RAM words
AW, 9, address width (2**AW == DEPTH_MEM)

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a run; sampled only in IDLE
abort  in  1  terminate a run in progress
mode  in  1  0: constant pattern = fill; 1: pattern = fill XOR zero-extended address
fill  in  WID_MEM  pattern seed
busy  out  1  run in progress; user writes are dropped while high
done  out  1  one-cycle pulse when a run completes (not on abort)
pass  out  1  last completed run had zero mismatches
err_count  out  AW+1  mismatches in last/current run
first_err_addr  out  AW  address of first mismatch in run
user_raddr  in  AW  user read address
user_waddr  in  AW  user write address
user_din  in  WID_MEM  user write data
user_dout  out  WID_MEM  equals mem_dout (always)
mem_raddr  out  AW  to RAM raddr
mem_waddr  out  AW  to RAM waddr
mem_din  out  WID_MEM  to RAM din
mem_dout  in  WID_MEM  from RAM dout; 1-cycle registered read, read-first on collision

Behaviour:
- Reset: FSM=IDLE; busy=0, done=0, pass=0, err_count=0, first_err_addr=0; address counter=0; latched mode/fill=0.
- The RAM writes every cycle, so mem_waddr/mem_din are always driven to a deliberate value. mem_* outputs are combinational from state/counter/latched pattern.
- States:
  - IDLE:
    - mem_raddr=user_raddr, mem_waddr=user_waddr, mem_din=user_din.
    - start=1 at edge -> latch mode/fill; clear err_count, first_err_addr, pass; addr=0; go to FILL.
  - FILL:
    - mem_waddr=mem_raddr=addr, mem_din=pattern(addr); addr increments each cycle.
    - addr==DEPTH_MEM-1 -> addr=0, go to VERIFY.
    - Takes exactly DEPTH_MEM cycles.
  - VERIFY:
    - mem_raddr=mem_waddr=addr, mem_din=pattern(addr). The rewrite is idempotent and keeps the RAM unchanged.
    - A compare pipeline register holds {valid, addr, expected} for one cycle.
    - Next cycle: mem_dout != expected -> err_count+1. first_err_addr captured only when err_count==0.
    - addr==DEPTH_MEM-1 -> go to DRAIN.
  - DRAIN (1 cycle):
    - Final compare happens here; mem_* driven as in VERIFY at addr DEPTH_MEM-1.
    - Go to DONE.
  - DONE (1 cycle):
    - done=1; pass set to (err_count==0); go to IDLE.
- pattern(a): mode_q ? fill_q ^ a (zero-extended) : fill_q.
- busy=1 in FILL, VERIFY, DRAIN, DONE.
- Timing: start sampled at edge k -> FILL cycles k+1..k+512, VERIFY k+513..k+1024, DRAIN k+1025, done high in cycle k+1026. Total 1026 cycles.
- start while busy: ignored.
- start and abort together in IDLE: start wins; abort is meaningless in IDLE.
- abort in any busy state:
  - Next state IDLE; no done pulse; pass=0.
  - err_count and first_err_addr hold their values at abort.
  - In-flight compare is discarded. RAM contents are partially written and unspecified.
- abort in the DONE cycle: done still pulses (run already complete).
- Reset mid-run: immediate return to reset values; RAM contents unspecified.
- err_count never overflows (max DEPTH_MEM fits in AW+1 bits).
- user_dout is always mem_dout. During busy it shows the controller's reads.

Test Plan:
- mode=0, fill=64'hA5A5_5A5A_DEAD_BEEF, start -> done exactly 1026 cycles after start edge, pass=1, err_count=0. Subsequent user reads of addrs 0, 255, 511 return the fill value one cycle after raddr.
- mode=1, fill=64'h0 -> pass=1. User read of addr 300 returns 64'h12C; addr 511 returns 64'h1FF.
- Bench RAM model flips dout bit 5 on reads of addrs 37 and 200 during VERIFY -> err_count=2, first_err_addr=37, pass=0, done pulses once.
- Abort 100 cycles into FILL -> busy drops next cycle, no done pulse, pass=0. A second start then runs to completion with pass=1.
- Start re-pulsed during VERIFY -> ignored: done exactly once at 1026 cycles from the original start.
- Reset asserted mid-VERIFY -> all outputs 0 asynchronously, FSM IDLE, mem_* follow user_* on the next cycle.

Source files
------------

// File: rtl/mem_reinit_sequencer.sv
// mem_reinit_sequencer
//
// Re-initialises a simple-dual-port block RAM. The RAM has one read port and
// one write port, and it writes on every clock. A run has two phases: it fills
// every word with a pattern, then reads every word back and compares it with
// that pattern. When no run is active, the user port passes straight through
// to the RAM.
//
// Handshake: start is a one-cycle request that is sampled only in IDLE and
// ignored at other times. done is a one-cycle completion pulse. pass,
// err_count and first_err_addr are stable from the done cycle until the next
// accepted start. abort ends a run early and produces no done pulse.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   start, abort            run request / run cancel
//   mode, fill              pattern select and seed, latched on start
//   busy, done, pass        run status
//   err_count               mismatches in the last or current run
//   first_err_addr          address of the first mismatch in the run
//   user_raddr/waddr/din    user RAM port, forwarded while idle
//   user_dout               RAM read data (always mem_dout)
//   mem_raddr/waddr/din     RAM address and data ports
//   mem_dout                RAM read data, one-cycle registered read
module mem_reinit_sequencer #(
    parameter int WID_MEM   = 64,
    parameter int DEPTH_MEM = 512,
    parameter int AW        = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               mode,
    input  logic [WID_MEM-1:0] fill,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [AW:0]        err_count,
    output logic [AW-1:0]      first_err_addr,
    input  logic [AW-1:0]      user_raddr,
    input  logic [AW-1:0]      user_waddr,
    input  logic [WID_MEM-1:0] user_din,
    output logic [WID_MEM-1:0] user_dout,
    output logic [AW-1:0]      mem_raddr,
    output logic [AW-1:0]      mem_waddr,
    output logic [WID_MEM-1:0] mem_din,
    input  logic [WID_MEM-1:0] mem_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_VERIFY,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [AW-1:0]      addr_q;
    logic [AW-1:0]      addr_nx;
    logic               mode_q;
    logic [WID_MEM-1:0] fill_q;
    logic [WID_MEM-1:0] pattern;
    logic               last_addr;

    // Compare pipeline. The RAM returns data one cycle after the address is
    // presented, so the expected word and its address wait here for one cycle.
    logic               cmp_valid;
    logic [AW-1:0]      cmp_addr;
    logic [WID_MEM-1:0] cmp_exp;
    logic               mismatch;
    logic [AW:0]        err_nx;

    assign last_addr = (addr_q == AW'(DEPTH_MEM - 1));
    assign pattern   = mode_q ? (fill_q ^ {{(WID_MEM-AW){1'b0}}, addr_q}) : fill_q;

    // An abort discards the compare that is in flight in that cycle.
    assign mismatch  = cmp_valid && !abort && (mem_dout != cmp_exp);
    assign err_nx    = err_count + {{AW{1'b0}}, mismatch};

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign user_dout = mem_dout;

    // The RAM writes every cycle. Every busy state drives the controller
    // address and pattern, so the writes in VERIFY, DRAIN and DONE rewrite
    // data that is already there.
    always_comb begin
        mem_raddr = user_raddr;
        mem_waddr = user_waddr;
        mem_din   = user_din;
        if (state != S_IDLE) begin
            mem_raddr = addr_q;
            mem_waddr = addr_q;
            mem_din   = pattern;
        end
    end

    always_comb begin
        state_nx = state;
        addr_nx  = addr_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_FILL;
                    addr_nx  = '0;
                end
            end
            S_FILL: begin
                if (abort) begin
                    state_nx = S_IDLE;
                    addr_nx  = '0;
                end else if (last_addr) begin
                    state_nx = S_VERIFY;
                    addr_nx  = '0;
                end else begin
                    addr_nx = addr_q + 1'b1;
                end
            end
            S_VERIFY: begin
                if (abort) begin
                    state_nx = S_IDLE;
                    addr_nx  = '0;
                end else if (last_addr) begin
                    // The address stays at the last word through DRAIN.
                    state_nx = S_DRAIN;
                end else begin
                    addr_nx = addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_nx = S_IDLE;
                    addr_nx  = '0;
                end else begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                // The run is complete, so an abort here changes nothing.
                state_nx = S_IDLE;
                addr_nx  = '0;
            end
            default: begin
                state_nx = S_IDLE;
                addr_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            addr_q         <= '0;
            mode_q         <= 1'b0;
            fill_q         <= '0;
            cmp_valid      <= 1'b0;
            cmp_addr       <= '0;
            cmp_exp        <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
        end else begin
            state     <= state_nx;
            addr_q    <= addr_nx;
            cmp_valid <= (state == S_VERIFY) && !abort;
            cmp_addr  <= addr_q;
            cmp_exp   <= pattern;
            if (state == S_IDLE && start) begin
                mode_q         <= mode;
                fill_q         <= fill;
                err_count      <= '0;
                first_err_addr <= '0;
                pass           <= 1'b0;
            end else begin
                if (mismatch) begin
                    err_count <= err_nx;
                    if (err_count == '0) begin
                        first_err_addr <= cmp_addr;
                    end
                end
                // The final compare completes in DRAIN, so pass is valid
                // during the done cycle.
                if (state == S_DRAIN) begin
                    pass <= !abort && (err_nx == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_reinit_sequencer.sv
// Testbench for mem_reinit_sequencer. It contains a behavioural 512x64 RAM
// model (registered read, read-first) and can corrupt selected read data.
// Expected run results and user read data are pushed into queues, and a
// monitor process checks them when done pulses or when a read returns.
module tb_mem_reinit_sequencer;
    localparam int W  = 64;
    localparam int D  = 512;
    localparam int AW = 9;
    localparam int RUN_CYCLES = 1026;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic          mode;
    logic [W-1:0]  fill;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW:0]   err_count;
    logic [AW-1:0] first_err_addr;
    logic [AW-1:0] user_raddr;
    logic [AW-1:0] user_waddr;
    logic [W-1:0]  user_din;
    logic [W-1:0]  user_dout;
    logic [AW-1:0] mem_raddr;
    logic [AW-1:0] mem_waddr;
    logic [W-1:0]  mem_din;
    logic [W-1:0]  mem_dout;

    mem_reinit_sequencer #(.WID_MEM(W), .DEPTH_MEM(D), .AW(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .mode           (mode),
        .fill           (fill),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .user_raddr     (user_raddr),
        .user_waddr     (user_waddr),
        .user_din       (user_din),
        .user_dout      (user_dout),
        .mem_raddr      (mem_raddr),
        .mem_waddr      (mem_waddr),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout)
    );

    // ---------------- clock / RAM model ----------------
    always #5 clk = ~clk;

    logic [W-1:0] ram [D];
    logic         inject = 1'b0;

    always @(posedge clk) begin
        mem_dout <= ram[mem_raddr] ^
                    ((inject && (mem_raddr == 9'd37 || mem_raddr == 9'd200)) ? 64'h20 : 64'h0);
        ram[mem_waddr] <= mem_din;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic          p;
        logic [AW:0]   ec;
        logic [AW-1:0] fa;
        int            start_cyc;
    } run_exp_t;

    run_exp_t     run_q[$];
    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic rd_issue = 1'b0;
    logic rd_pipe = 1'b0;
    run_exp_t cur;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_pipe <= rd_issue;

    always @(negedge clk) begin
        if (!reset && done) begin
            done_cnt++;
            if (run_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                cur = run_q.pop_front();
                check("run_pass", pass, cur.p);
                check("run_err_count", err_count, cur.ec);
                check("run_first_err_addr", first_err_addr, cur.fa);
                check("run_latency", cyc - cur.start_cyc + 1, RUN_CYCLES);
            end
        end
        if (rd_pipe) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL read_underflow: got read data %h expected none", user_dout);
            end else begin
                check("user_dout", user_dout, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic m, input logic [W-1:0] f, input logic push,
                            input logic p, input logic [AW:0] ec, input logic [AW-1:0] fa);
        run_exp_t r;
        mode  = m;
        fill  = f;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (push) begin
            r.p = p;
            r.ec = ec;
            r.fa = fa;
            r.start_cyc = cyc;
            run_q.push_back(r);
        end
    endtask

    task automatic wait_done(input string name);
        int base;
        int n;
        base = done_cnt;
        n = 0;
        while (done_cnt == base && n < 1200) begin
            tick();
            n++;
        end
        if (done_cnt == base) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, n);
        end
        tick();
    endtask

    task automatic user_read(input logic [AW-1:0] a, input logic [W-1:0] e);
        user_raddr = a;
        exp_q.push_back(e);
        rd_issue = 1'b1;
        tick();
        rd_issue = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    localparam logic [W-1:0] FILL_A = 64'hA5A5_5A5A_DEAD_BEEF;
    localparam logic [W-1:0] FILL_E = 64'hFFFF_0000_1234_5678;
    localparam logic [W-1:0] WR_X   = 64'h0123_4567_89AB_CDEF;
    localparam logic [W-1:0] WR_Y   = 64'hFEDC_BA98_7654_3210;

    initial begin
        int base;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mode = 1'b0;
        fill = '0;
        user_raddr = 9'd0;
        user_waddr = 9'd400;
        user_din = '0;
        for (int i = 0; i < D; i++) ram[i] = '0;

        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err_count", err_count, 0);
        check("rst_first_err_addr", first_err_addr, 0);
        reset = 1'b0;
        tick();
        check("idle_waddr", mem_waddr, 400);

        // Run in mode 0, then read words back through the user port.
        do_start(1'b0, FILL_A, 1'b1, 1'b1, 0, 0);
        check("busy_after_start", busy, 1);
        wait_done("run_a");
        check("idle_after_run", busy, 0);
        user_read(9'd0, FILL_A);
        user_read(9'd255, FILL_A);
        user_read(9'd511, FILL_A);

        // User write through the idle path, and a read-first collision.
        user_din = WR_X;
        tick();
        check("idle_din", mem_din, WR_X);
        user_din = WR_Y;
        user_read(9'd400, WR_X);
        user_read(9'd400, WR_Y);
        user_din = '0;

        // Run in mode 1 with fill 0: each word equals its own address.
        do_start(1'b1, 64'h0, 1'b1, 1'b1, 0, 0);
        wait_done("run_b");
        user_read(9'd300, 64'h12C);
        user_read(9'd511, 64'h1FF);
        user_read(9'd0, 64'h0);

        // Corrupted reads at addresses 37 and 200 during VERIFY.
        inject = 1'b1;
        do_start(1'b0, FILL_E, 1'b1, 1'b0, 2, 37);
        wait_done("run_inject");
        inject = 1'b0;
        user_read(9'd37, FILL_E);

        // Abort during FILL.
        base = done_cnt;
        do_start(1'b0, 64'h55, 1'b0, 1'b0, 0, 0);
        repeat (99) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_pass", pass, 0);
        check("abort_err_count", err_count, 0);
        repeat (20) tick();
        check("abort_no_done", done_cnt, base);
        do_start(1'b0, 64'h0000_FFFF_0000_FFFF, 1'b1, 1'b1, 0, 0);
        wait_done("run_after_abort");

        // A second start during VERIFY is ignored.
        do_start(1'b1, 64'hF0F0_0F0F_3C3C_C3C3, 1'b1, 1'b1, 0, 0);
        repeat (600) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("run_repulse");
        base = done_cnt;
        repeat (50) tick();
        check("repulse_single_done", done_cnt, base);
        check("repulse_idle", busy, 0);

        // Reset during VERIFY, after two mismatches have been counted.
        inject = 1'b1;
        user_raddr = 9'd123;
        user_din = 64'h77;
        do_start(1'b0, 64'h1, 1'b0, 1'b0, 0, 0);
        repeat (800) tick();
        check("pre_reset_err_count", err_count, 2);
        check("pre_reset_first_err", first_err_addr, 37);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_pass", pass, 0);
        check("async_rst_err_count", err_count, 0);
        check("async_rst_first_err", first_err_addr, 0);
        check("async_rst_raddr", mem_raddr, 123);
        inject = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_raddr", mem_raddr, 123);
        check("post_rst_waddr", mem_waddr, 400);
        check("post_rst_din", mem_din, 64'h77);
        check("post_rst_busy", busy, 0);

        repeat (3) tick();
        check("leftover_runs", run_q.size(), 0);
        check("leftover_reads", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
